// File: rtl/key_conditioner.sv
// Button conditioning: polarity normalisation, 2-flop synchroniser and a
// per-key stability counter producing clean levels plus press/release strobes.
module key_conditioner #(
  parameter int KEYS_W        = 4,
  parameter int BOARD_CLK_MHZ = 25,
  parameter int DEBOUNCE_MS   = 10,
  parameter bit KEYS_ACT_LOW  = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [KEYS_W-1:0] keys_raw_i,
  output logic [KEYS_W-1:0] keys_o,
  output logic [KEYS_W-1:0] press_o,
  output logic [KEYS_W-1:0] release_o,
  output logic              any_press_o
);

  localparam int DB_CYCLES = BOARD_CLK_MHZ * 1000 * DEBOUNCE_MS;
  localparam int CNT_W     = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("key_conditioner: DB_CYCLES must be at least 2");
  end

  logic [KEYS_W-1:0] n_keys;
  logic [KEYS_W-1:0] s1_q, s2_q;
  logic [KEYS_W-1:0] keys_q, press_q, release_q;
  logic [KEYS_W-1:0] keys_d, press_d, release_d;
  logic              any_press_q;

  assign n_keys = KEYS_ACT_LOW ? ~keys_raw_i : keys_raw_i;

  // Only the first synchroniser stage ever looks at the raw pins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q        <= '0;
      s2_q        <= '0;
      keys_q      <= '0;
      press_q     <= '0;
      release_q   <= '0;
      any_press_q <= 1'b0;
    end else begin
      s1_q        <= n_keys;
      s2_q        <= s1_q;
      keys_q      <= keys_d;
      press_q     <= press_d;
      release_q   <= release_d;
      any_press_q <= |press_d;
    end
  end

  for (genvar gi = 0; gi < KEYS_W; gi++) begin : g_key
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             key_d, prs_d, rel_d;

    // Any return to the stable level throws away the accumulated time.
    always_comb begin
      cnt_d = '0;
      key_d = keys_q[gi];
      prs_d = 1'b0;
      rel_d = 1'b0;
      if (s2_q[gi] != keys_q[gi]) begin
        if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
          key_d = s2_q[gi];
          prs_d = s2_q[gi];
          rel_d = ~s2_q[gi];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign keys_d[gi]    = key_d;
    assign press_d[gi]   = prs_d;
    assign release_d[gi] = rel_d;
  end

  assign keys_o      = keys_q;
  assign press_o     = press_q;
  assign release_o   = release_q;
  assign any_press_o = any_press_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner with DB_CYCLES = 1000 and two
// active-low keys; expected strobe events are queued when stimulus is driven.
module tb_key_conditioner;

  localparam int LAT = 1002;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] keys_raw = 2'b11;
  logic [1:0] keys_o, press_o, release_o;
  logic       any_press_o;

  int cyc = 0;
  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int         at_cyc;
    logic [1:0] press;
    logic [1:0] rel;
    logic       any;
    logic [1:0] keys;
  } ev_t;

  ev_t q[$];

  key_conditioner #(
    .KEYS_W       (2),
    .BOARD_CLK_MHZ(1),
    .DEBOUNCE_MS  (1),
    .KEYS_ACT_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .keys_raw_i (keys_raw),
    .keys_o     (keys_o),
    .press_o    (press_o),
    .release_o  (release_o),
    .any_press_o(any_press_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input logic [1:0] p, input logic [1:0] r,
                           input logic a, input logic [1:0] k);
    ev_t e;
    e.at_cyc = at; e.press = p; e.rel = r; e.any = a; e.keys = k;
    q.push_back(e);
  endtask

  task automatic drain(input string name, input logic [1:0] keys_exp);
    int t = 0;
    while (q.size() != 0 && t < LAT + 200) begin
      step(1);
      t++;
    end
    step(3);
    n_total++;
    if (q.size() == 0) n_pass++;
    else begin
      $display("FAIL %s_timeout: %0d events still pending, required 0", name, q.size());
      q.delete();
    end
    n_total++;
    if (keys_o === keys_exp) n_pass++;
    else $display("FAIL %s_keys: keys_o=%b required %b", name, keys_o, keys_exp);
  endtask

  task automatic check_clear(input string name);
    n_total++;
    if (keys_o === 2'b00 && press_o === 2'b00 && release_o === 2'b00 && any_press_o === 1'b0)
      n_pass++;
    else
      $display("FAIL %s: keys=%b press=%b rel=%b any=%b required all 0",
               name, keys_o, press_o, release_o, any_press_o);
  endtask

  task automatic test_reset();
    step(5);
    check_clear("reset_state");
    rst_n = 1'b1;
    step(20);
    check_clear("idle_after_reset");
  endtask

  task automatic test_clean_press();
    keys_raw = 2'b10;
    expect_ev(cyc + LAT, 2'b01, 2'b00, 1'b1, 2'b01);
    drain("clean_press", 2'b01);
  endtask

  task automatic test_release();
    keys_raw = 2'b11;
    expect_ev(cyc + LAT, 2'b00, 2'b01, 1'b0, 2'b00);
    drain("release", 2'b00);
  endtask

  task automatic test_bounce();
    for (int k = 0; k < 10; k++) begin
      keys_raw = (k % 2 == 0) ? 2'b10 : 2'b11;
      step(300);
    end
    n_total++;
    if (keys_o === 2'b00) n_pass++;
    else $display("FAIL bounce_level: keys_o=%b required 00", keys_o);
    keys_raw = 2'b10;
    expect_ev(cyc + LAT, 2'b01, 2'b00, 1'b1, 2'b01);
    drain("bounce_press", 2'b01);
    keys_raw = 2'b11;
    expect_ev(cyc + LAT, 2'b00, 2'b01, 1'b0, 2'b00);
    drain("bounce_release", 2'b00);
  endtask

  task automatic test_simultaneous();
    keys_raw = 2'b00;
    expect_ev(cyc + LAT, 2'b11, 2'b00, 1'b1, 2'b11);
    drain("simul_press", 2'b11);
    keys_raw = 2'b11;
    expect_ev(cyc + LAT, 2'b00, 2'b11, 1'b0, 2'b00);
    drain("simul_release", 2'b00);
  endtask

  task automatic test_held_through_reset();
    rst_n = 1'b0;
    keys_raw = 2'b01;
    #1;
    check_clear("held_reset_assert");
    step(8);
    check_clear("held_during_reset");
    rst_n = 1'b1;
    expect_ev(cyc + LAT, 2'b10, 2'b00, 1'b1, 2'b10);
    drain("held_reset_press", 2'b10);
  endtask

  // Key 1 is already debounced-pressed so the asynchronous clear is visible.
  task automatic test_mid_pending_reset();
    keys_raw = 2'b00;
    step(500);
    n_total++;
    if (keys_o === 2'b10) n_pass++;
    else $display("FAIL midpend_before: keys_o=%b required 10", keys_o);
    rst_n = 1'b0;
    #1;
    check_clear("midpend_async_clear");
    step(10);
    rst_n = 1'b1;
    expect_ev(cyc + LAT, 2'b11, 2'b00, 1'b1, 2'b11);
    drain("midpend_press", 2'b11);
    keys_raw = 2'b11;
    expect_ev(cyc + LAT, 2'b00, 2'b11, 1'b0, 2'b00);
    drain("midpend_release", 2'b00);
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (press_o !== 2'b00 || release_o !== 2'b00 || any_press_o !== 1'b0) begin
          n_total++;
          if (q.size() == 0) begin
            $display("FAIL unexpected_strobe: cyc=%0d press=%b rel=%b any=%b required none",
                     cyc, press_o, release_o, any_press_o);
          end else begin
            ev_t e;
            e = q.pop_front();
            if (cyc === e.at_cyc && press_o === e.press && release_o === e.rel &&
                any_press_o === e.any && keys_o === e.keys) begin
              n_pass++;
              $display("event ok: cyc=%0d press=%b rel=%b any=%b keys=%b",
                       cyc, press_o, release_o, any_press_o, keys_o);
            end else begin
              $display("FAIL strobe_event: cyc=%0d press=%b rel=%b any=%b keys=%b required cyc=%0d press=%b rel=%b any=%b keys=%b",
                       cyc, press_o, release_o, any_press_o, keys_o,
                       e.at_cyc, e.press, e.rel, e.any, e.keys);
            end
          end
        end
      end
    join_none

    @(negedge clk);
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_simultaneous();
    test_held_through_reset();
    test_mid_pending_reset();
    step(20);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
